// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns (active-low gfedcba) and BCD decode shared by the display blocks
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD + blank -> active-low segments
//   bcd   in  4  digit value, 10..15 shown as a dash
//   blank in  1  force all segments off
//   seg   out 7  gfedcba, active-low
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);
    assign seg = blank ? SEG_BLANK : bcd_to_seg(bcd);
endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: frame-snapshotted 4-digit multiplexer with blanking, dead time and dimming
//   clk, reset              clock, async active-high reset
//   digit0..digit3          BCD digits, digit0 rightmost
//   dp_mask, blank_lz, duty decimal points, leading-zero blanking, brightness
//   an, seg, dp             active-low anodes (bit i = digit i), segments, decimal point
//   frame_tick              one-clock pulse after each snapshot
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int DEAD     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] dp_mask,
    input  logic       blank_lz,
    input  logic [1:0] duty,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);
    localparam int CW = $clog2(PRESCALE);
    logic [CW-1:0]   cnt;
    logic [1:0]      slot;
    logic [3:0][3:0] sh_digit;
    logic [3:0]      sh_dp;
    logic            sh_lz;
    logic [1:0]      sh_duty;
    logic [3:0]      blank;
    logic [31:0]     on_end;
    logic            last, frame_end, win;
    logic [6:0]      seg_next;
    assign last      = cnt == CW'(PRESCALE - 1);
    assign frame_end = last && slot == 2'd3;
    // Blanking cascades from the leftmost digit; digit0 always shows
    assign blank[3] = sh_lz && sh_digit[3] == 4'd0;
    assign blank[2] = blank[3] && sh_digit[2] == 4'd0;
    assign blank[1] = blank[2] && sh_digit[1] == 4'd0;
    assign blank[0] = 1'b0;
    assign on_end = (32'(sh_duty) + 32'd1) * 32'(PRESCALE / 4);
    assign win    = 32'(cnt) >= 32'(DEAD) && 32'(cnt) < on_end;
    seg7_decode u_decode (
        .bcd  (sh_digit[slot]),
        .blank(blank[slot]),
        .seg  (seg_next)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            slot       <= 2'd0;
            sh_digit   <= '0;
            sh_dp      <= 4'b0000;
            sh_lz      <= 1'b1;
            sh_duty    <= 2'd3;
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            cnt  <= last ? '0 : cnt + CW'(1);
            slot <= last ? slot + 2'd1 : slot;
            if (frame_end) begin
                sh_digit <= {digit3, digit2, digit1, digit0};
                sh_dp    <= dp_mask;
                sh_lz    <= blank_lz;
                sh_duty  <= duty;
            end
            an         <= win ? ~(4'b0001 << slot) : AN_OFF;
            seg        <= seg_next;
            dp         <= ~(win && !blank[slot] && sh_dp[slot]);
            frame_tick <= frame_end;
        end
    end
endmodule
